// File: rtl/reg_writeback_pkg.sv
// Shared widths, defaults and types for the register writeback stage.
// Imported by the writeback top and its tag FIFO user.
package reg_writeback_pkg;

   localparam int unsigned REG_W     = 16;
   localparam int unsigned RADDR_W   = 3;
   localparam int unsigned NREGS     = 8;
   localparam int unsigned DEPTH_DEF = 2;

   typedef logic [RADDR_W-1:0] raddr_t;
   typedef logic [REG_W-1:0]   rdata_t;
   typedef logic [NREGS-1:0]   rmask_t;

   // One pending register-file write: enable, address and data.
   typedef struct packed {
      logic   we;
      raddr_t addr;
      rdata_t data;
   } wb_t;

   function automatic rmask_t onehot(input raddr_t a);
      rmask_t m;
      m    = '0;
      m[a] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/wb_tag_fifo.sv
// Small FIFO of load destination tags, returned in issue order.
// Pointers wrap modulo DEPTH so non power-of-two depths work.
module wb_tag_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 3,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty     = (r_count == '0);
   assign full      = (r_count == CNT_W'(DEPTH));
   assign count     = r_count;
   assign head      = r_mem[r_rd_ptr];
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/reg_writeback.sv
// Writeback arbiter merging ALU results and in-order load returns into one
// registered register-file write port, with WAW tracking via a pending mask.
module reg_writeback
   import reg_writeback_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               alu_valid,
   input  logic [RADDR_W-1:0] alu_rd,
   input  logic [REG_W-1:0]   alu_data,
   output logic               alu_ready,
   input  logic               ld_req_valid,
   input  logic [RADDR_W-1:0] ld_rd,
   output logic               ld_req_ready,
   input  logic               ld_resp_valid,
   input  logic [REG_W-1:0]   ld_resp_data,
   output logic               RegWrite_Flag,
   output logic [RADDR_W-1:0] Wreg,
   output logic [REG_W-1:0]   Datain,
   output logic [NREGS-1:0]   busy_mask,
   output logic               resp_err
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   wb_t                r_wb;
   rmask_t             r_pend;
   logic               r_resp_err;
   rmask_t             w_pend_d;
   raddr_t             w_head;
   logic [CNT_W-1:0]   w_count;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_alu_fire;

   wb_tag_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (RADDR_W)
   ) u_tag_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (w_push),
      .push_data (ld_rd),
      .pop       (w_pop),
      .head      (w_head),
      .count     (w_count),
      .full      (w_full),
      .empty     (w_empty)
   );

   // Fullness is judged on pre-edge state, so a same-cycle pop never frees a slot.
   assign ld_req_ready = ~w_full & ~r_pend[ld_rd] & ~(r_wb.we & (r_wb.addr == ld_rd));
   assign alu_ready    = ~ld_resp_valid & ~r_pend[alu_rd];

   assign w_push     = ld_req_valid & ld_req_ready;
   assign w_pop      = ld_resp_valid & ~w_empty;
   assign w_alu_fire = alu_valid & alu_ready;

   // Set is applied after clear so a same-bit set/clear leaves the bit set.
   always_comb begin
      w_pend_d = r_pend;
      if (w_pop) begin
         w_pend_d = w_pend_d & ~onehot(w_head);
      end
      if (w_push) begin
         w_pend_d = w_pend_d | onehot(ld_rd);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wb       <= '0;
         r_pend     <= '0;
         r_resp_err <= 1'b0;
      end else begin
         r_pend <= w_pend_d;
         if (ld_resp_valid && w_empty) begin
            r_resp_err <= 1'b1;
         end
         if (w_pop) begin
            r_wb <= '{we: 1'b1, addr: w_head, data: ld_resp_data};
         end else if (w_alu_fire) begin
            r_wb <= '{we: 1'b1, addr: alu_rd, data: alu_data};
         end else begin
            r_wb.we <= 1'b0;
         end
      end
   end

   assign RegWrite_Flag = r_wb.we;
   assign Wreg          = r_wb.addr;
   assign Datain        = r_wb.data;
   assign resp_err      = r_resp_err;
   assign busy_mask     = r_pend | (r_wb.we ? onehot(r_wb.addr) : '0);

   assert property (@(posedge clk) disable iff (!rstn) w_full == (w_count == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized bench for reg_writeback: a queue-based model of outstanding loads
// and the write port is compared against the DUT every cycle.
module tb_reg_writeback;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        alu_valid = 1'b0;
   logic [2:0]  alu_rd = '0;
   logic [15:0] alu_data = '0;
   logic        alu_ready;
   logic        ld_req_valid = 1'b0;
   logic [2:0]  ld_rd = '0;
   logic        ld_req_ready;
   logic        ld_resp_valid = 1'b0;
   logic [15:0] ld_resp_data = '0;
   logic        RegWrite_Flag;
   logic [2:0]  Wreg;
   logic [15:0] Datain;
   logic [7:0]  busy_mask;
   logic        resp_err;

   always #5 clk = ~clk;

   reg_writeback #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .alu_valid     (alu_valid),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .alu_ready     (alu_ready),
      .ld_req_valid  (ld_req_valid),
      .ld_rd         (ld_rd),
      .ld_req_ready  (ld_req_ready),
      .ld_resp_valid (ld_resp_valid),
      .ld_resp_data  (ld_resp_data),
      .RegWrite_Flag (RegWrite_Flag),
      .Wreg          (Wreg),
      .Datain        (Datain),
      .busy_mask     (busy_mask),
      .resp_err      (resp_err)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: outstanding load destinations in issue order, plus the write port.
   int        m_q[$];
   bit        m_we = 1'b0;
   bit [2:0]  m_wreg = '0;
   bit [15:0] m_data = '0;
   bit        m_err = 1'b0;

   function automatic bit in_q(input int r);
      foreach (m_q[i]) if (m_q[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit [7:0] m_busy();
      bit [7:0] b = '0;
      foreach (m_q[i]) b[m_q[i]] = 1'b1;
      if (m_we) b[m_wreg] = 1'b1;
      return b;
   endfunction

   function automatic bit m_alu_rdy();
      return !ld_resp_valid && !in_q(int'(alu_rd));
   endfunction

   function automatic bit m_ld_rdy();
      return (m_q.size() < DEPTH) && !in_q(int'(ld_rd)) && !(m_we && m_wreg == ld_rd);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin : model
      forever begin
         bit pop, push, afire;
         @(posedge clk or negedge rstn);
         if (!rstn) begin
            m_q.delete();
            m_we   = 1'b0;
            m_wreg = '0;
            m_data = '0;
            m_err  = 1'b0;
         end else begin
            pop   = ld_resp_valid && (m_q.size() > 0);
            push  = ld_req_valid && m_ld_rdy();
            afire = alu_valid && m_alu_rdy();
            if (ld_resp_valid && m_q.size() == 0) m_err = 1'b1;
            if (pop) begin
               m_we   = 1'b1;
               m_wreg = 3'(m_q.pop_front());
               m_data = ld_resp_data;
            end else if (afire) begin
               m_we   = 1'b1;
               m_wreg = alu_rd;
               m_data = alu_data;
            end else begin
               m_we = 1'b0;
            end
            if (push) m_q.push_back(int'(ld_rd));
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         #3;
         chk("RegWrite_Flag", 32'(RegWrite_Flag), 32'(m_we));
         chk("Wreg", 32'(Wreg), 32'(m_wreg));
         chk("Datain", 32'(Datain), 32'(m_data));
         chk("busy_mask", 32'(busy_mask), 32'(m_busy()));
         chk("resp_err", 32'(resp_err), 32'(m_err));
         chk("alu_ready", 32'(alu_ready), 32'(m_alu_rdy()));
         chk("ld_req_ready", 32'(ld_req_ready), 32'(m_ld_rdy()));
      end
   end

   // Drive one cycle of inputs at the falling edge; returns after the compare point.
   task automatic cyc(input bit av, input bit [2:0] ard, input bit [15:0] ad, input bit lv,
                      input bit [2:0] lrd, input bit rv, input bit [15:0] rdat);
      @(negedge clk);
      alu_valid     = av;
      alu_rd        = ard;
      alu_data      = ad;
      ld_req_valid  = lv;
      ld_rd         = lrd;
      ld_resp_valid = rv;
      ld_resp_data  = rdat;
      #4;
   endtask

   task automatic idle();
      cyc(0, 0, 16'h0, 0, 0, 0, 16'h0);
   endtask

   initial begin : stim
      repeat (2) @(negedge clk);
      chk("reset_we", 32'(RegWrite_Flag), 32'h0);
      chk("reset_busy", 32'(busy_mask), 32'h0);
      chk("reset_err", 32'(resp_err), 32'h0);
      rstn = 1'b1;

      // ALU write
      cyc(1, 3, 16'h1234, 0, 0, 0, 16'h0);
      chk("alu_rdy_basic", 32'(alu_ready), 32'h1);
      idle();
      chk("alu_we", 32'(RegWrite_Flag), 32'h1);
      chk("alu_wreg", 32'(Wreg), 32'h3);
      chk("alu_data", 32'(Datain), 32'h1234);
      chk("alu_busy", 32'(busy_mask), 32'h08);
      idle();
      chk("alu_we_drop", 32'(RegWrite_Flag), 32'h0);

      // Load issue and return
      cyc(0, 0, 16'h0, 1, 5, 0, 16'h0);
      chk("ld_rdy_basic", 32'(ld_req_ready), 32'h1);
      idle();
      chk("ld_busy", 32'(busy_mask), 32'h20);
      cyc(0, 0, 16'h0, 0, 0, 1, 16'hBEEF);
      chk("ld_busy_resp", 32'(busy_mask), 32'h20);
      idle();
      chk("ld_we", 32'(RegWrite_Flag), 32'h1);
      chk("ld_wreg", 32'(Wreg), 32'h5);
      chk("ld_data", 32'(Datain), 32'hBEEF);
      idle();
      chk("ld_busy_clear", 32'(busy_mask), 32'h0);

      // Collision: load response wins over ALU
      cyc(0, 0, 16'h0, 1, 6, 0, 16'h0);
      cyc(1, 2, 16'h2222, 0, 0, 1, 16'h1111);
      chk("coll_alu_rdy", 32'(alu_ready), 32'h0);
      cyc(1, 2, 16'h2222, 0, 0, 0, 16'h0);
      chk("coll_ld_wreg", 32'(Wreg), 32'h6);
      chk("coll_ld_data", 32'(Datain), 32'h1111);
      chk("coll_alu_rdy2", 32'(alu_ready), 32'h1);
      idle();
      chk("coll_alu_wreg", 32'(Wreg), 32'h2);
      chk("coll_alu_data", 32'(Datain), 32'h2222);

      // WAW hazard against a pending load
      cyc(0, 0, 16'h0, 1, 4, 0, 16'h0);
      cyc(1, 4, 16'h4040, 0, 0, 0, 16'h0);
      chk("waw_alu_rdy", 32'(alu_ready), 32'h0);
      cyc(1, 4, 16'h4040, 0, 0, 1, 16'h4444);
      chk("waw_alu_rdy_resp", 32'(alu_ready), 32'h0);
      cyc(1, 4, 16'h4040, 0, 0, 0, 16'h0);
      chk("waw_ld_data", 32'(Datain), 32'h4444);
      chk("waw_alu_rdy_after", 32'(alu_ready), 32'h1);
      idle();
      chk("waw_alu_data", 32'(Datain), 32'h4040);

      // Capacity: third load blocked even with a response in the same cycle
      cyc(0, 0, 16'h0, 1, 1, 0, 16'h0);
      chk("cap_rdy1", 32'(ld_req_ready), 32'h1);
      cyc(0, 0, 16'h0, 1, 2, 0, 16'h0);
      chk("cap_rdy2", 32'(ld_req_ready), 32'h1);
      cyc(0, 0, 16'h0, 1, 3, 1, 16'h0101);
      chk("cap_full_rdy", 32'(ld_req_ready), 32'h0);
      cyc(0, 0, 16'h0, 1, 3, 0, 16'h0);
      chk("cap_rdy3", 32'(ld_req_ready), 32'h1);
      cyc(0, 0, 16'h0, 0, 0, 1, 16'h0202);
      cyc(0, 0, 16'h0, 0, 0, 1, 16'h0303);
      chk("cap_wreg2", 32'(Wreg), 32'h2);
      chk("cap_data2", 32'(Datain), 32'h0202);
      idle();
      chk("cap_wreg3", 32'(Wreg), 32'h3);
      chk("cap_data3", 32'(Datain), 32'h0303);
      idle();

      // Spurious response
      cyc(0, 0, 16'h0, 0, 0, 1, 16'hBAD0);
      idle();
      chk("err_no_write", 32'(RegWrite_Flag), 32'h0);
      chk("err_flag", 32'(resp_err), 32'h1);

      // Async reset mid-load with a write in flight
      cyc(1, 7, 16'h7777, 1, 5, 0, 16'h0);
      idle();
      chk("pre_rst_busy", 32'(busy_mask), 32'hA0);
      rstn = 1'b0;
      #1;
      chk("rst_we", 32'(RegWrite_Flag), 32'h0);
      chk("rst_wreg", 32'(Wreg), 32'h0);
      chk("rst_data", 32'(Datain), 32'h0);
      chk("rst_busy", 32'(busy_mask), 32'h0);
      chk("rst_err", 32'(resp_err), 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      cyc(0, 0, 16'h0, 0, 0, 1, 16'hDEAD);
      idle();
      chk("post_rst_we", 32'(RegWrite_Flag), 32'h0);
      chk("post_rst_err", 32'(resp_err), 32'h1);

      // Randomized traffic with occasional async resets
      for (int i = 0; i < 3000; i++) begin
         bit rv;
         rv = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
         cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
             1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), rv, 16'($urandom));
         if ($urandom_range(0, 199) == 0) begin
            rstn = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
         end
      end
      repeat (3) idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising edge); rstn input 1 (asynchronous assert, active-low).
REQ-002 Parameter DEPTH, default 2: maximum number of outstanding loads.
REQ-003 alu_valid input 1: ALU result offered this cycle.
REQ-004 alu_rd input 3: ALU destination register.
REQ-005 alu_data input 16: ALU result.
REQ-006 alu_ready output 1: ALU result accepted this cycle when alu_valid is also high.
REQ-007 ld_req_valid input 1: load issued to memory.
REQ-008 ld_rd input 3: load destination register.
REQ-009 ld_req_ready output 1: load issue accepted.
REQ-010 ld_resp_valid input 1: load data returned, in issue order; cannot be stalled.
REQ-011 ld_resp_data input 16: load data.
REQ-012 RegWrite_Flag output 1: register-file write enable.
REQ-013 Wreg output 3: register-file write address.
REQ-014 Datain output 16: register-file write data.
REQ-015 busy_mask output 8: bit r high = register r has a write not yet committed to the register file.
REQ-016 resp_err output 1: sticky flag for a load response with no outstanding load.

Function
REQ-017 A tag FIFO of DEPTH 3-bit entries SHALL hold outstanding load destinations; push = ld_req_valid & ld_req_ready; pop = ld_resp_valid & FIFO not empty.
REQ-018 Pending vector pend[7:0] SHALL set bit ld_rd on push and clear bit head-tag on pop; set and clear of the same bit in one cycle SHALL leave it set.
REQ-019 ld_req_ready SHALL equal (count < DEPTH) & !pend[ld_rd] & !(RegWrite_Flag & Wreg == ld_rd), using pre-edge state; a pop in the same cycle SHALL NOT free a slot early.
REQ-020 alu_ready SHALL equal !ld_resp_valid & !pend[alu_rd]: load response has priority; ALU stalls on WAW against a pending load.
REQ-021 Output register (RegWrite_Flag, Wreg, Datain) SHALL load on each edge: pop -> (1, head tag, ld_resp_data); else alu_valid & alu_ready -> (1, alu_rd, alu_data); else RegWrite_Flag <= 0, Wreg/Datain hold.
REQ-022 Latency SHALL be exactly one cycle from accepted input to RegWrite_Flag high; the register file commits on the following edge.
REQ-023 busy_mask SHALL equal pend OR (RegWrite_Flag ? onehot(Wreg) : 0), combinational from registered state only.
REQ-024 ld_resp_valid with FIFO empty SHALL cause no write and no state change except resp_err <= 1; resp_err clears only on reset.
REQ-025 Push and pop in the same cycle SHALL keep count unchanged and remain correct when count = DEPTH, with pointers wrapping modulo DEPTH.
REQ-026 Writes to register 0 SHALL be handled as for any other register.

Reset
REQ-027 rstn low SHALL immediately clear RegWrite_Flag, Wreg, Datain, pend, FIFO pointers, count and resp_err; alu_ready and ld_req_ready then follow their equations from the cleared state.
REQ-028 Loads outstanding when reset asserts SHALL be discarded; any later response SHALL set resp_err.

Structure
REQ-029 A shared package SHALL hold REG_W = 16, RADDR_W = 3, NREGS = 8 and DEPTH's default.
REQ-030 The tag FIFO SHALL be a sub-module, wb_tag_fifo (parameters DEPTH and width; push, pop, head, count, full, empty).

Verification
REQ-031 ALU write: alu_valid=1, alu_rd=3, alu_data=16'h1234 -> next cycle RegWrite_Flag=1, Wreg=3, Datain=16'h1234, busy_mask=8'h08; following cycle RegWrite_Flag=0.
REQ-032 Load: issue ld_rd=5 -> busy_mask=8'h20; response 16'hBEEF two cycles later -> Wreg=5, Datain=16'hBEEF; busy_mask=0 after the commit edge.
REQ-033 Collision: ld_resp_valid and alu_valid (rd=2) in the same cycle -> alu_ready=0; load written first, ALU write one cycle later.
REQ-034 Hazards: pending load to r4, ALU rd=4 -> alu_ready=0 until the load write commits; two loads pending (r1, r2) -> third load ld_req_ready=0, even in a cycle with a response.
REQ-035 Error and reset: response with FIFO empty -> no write, resp_err=1; rstn low mid-load -> all outputs 0 asynchronously, and a later response sets resp_err.
